// File: rtl/msk_and_ghpc_vec.sv
`default_nettype none
// ============================================================================
//  Module   : msk_and_ghpc_vec
//  Purpose  : W independent first-order masked AND gates (2-share GHPC).
//             Each lane uses one fresh random bit and has a 2-cycle latency.
//             Output share 0 is the lane's random bit, delayed. Output share 1
//             is the precomputed table entry selected by the registered
//             share-1 operands.
//  Ports    : clk       - clock, rising edge
//             rst_n     - synchronous active-low reset (overrides en)
//             en        - pipeline advance; 0 holds every register
//             in_valid  - ina/inb/rnd carry a valid operand set
//             ina, inb  - 2*W shared operands, [W-1:0] share0, [2W-1:W] share1
//             rnd       - W fresh random bits, one per lane
//             out_valid - out holds a valid result
//             out       - 2*W sharing of ina&inb, same packing
//  Options  : define MSK_AND_GHPC_VEC_OUTZERO_EN to force out to 0 while
//             out_valid is low
//  Revision : 1.0 - initial release
// ============================================================================
module msk_and_ghpc_vec #(
  parameter int W = 8,
  parameter int d = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  input  logic [2*W-1:0] ina,
  input  logic [2*W-1:0] inb,
  input  logic [W-1:0]   rnd,
  output logic           out_valid,
  output logic [2*W-1:0] out
);

  // Only the 2-share construction is implemented.
  generate
    if (d != 2) begin : g_bad_d
      $error("msk_and_ghpc_vec: only d=2 is supported");
    end
  endgenerate

  logic [W-1:0]   w_out0;
  logic [W-1:0]   w_out1;
  logic [2*W-1:0] w_data;
  logic           r_vld1;
  logic           r_vld2;

  genvar i;
  generate
    for (i = 0; i < W; i++) begin : g_lane
      logic [3:0] w_t;
      logic [3:0] w_sel;
      logic       w_s;
      logic [3:0] r_t;
      logic       r_a1;
      logic       r_b1;
      logic       r_rnd1;
      logic       r_s;
      logic       r_rnd2;

      // Table of every possible share-1 value pair. Only share 0 is used
      // combinationally here. Share 1 waits in a register so that the two
      // shares never meet in the same combinational cone.
      always_comb begin
        w_t = '0;
        for (int k = 0; k < 4; k++) begin
          w_t[k] = ((ina[i] ^ k[1]) & (inb[i] ^ k[0])) ^ rnd[i];
        end
      end

      // Select the table entry with a one-hot mask and an XOR tree, not a
      // mux, so that no data-dependent glitches leak through the selection.
      assign w_sel = 4'b0001 << {r_a1, r_b1};
      assign w_s   = ^(r_t & w_sel);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_t    <= '0;
          r_a1   <= 1'b0;
          r_b1   <= 1'b0;
          r_rnd1 <= 1'b0;
          r_s    <= 1'b0;
          r_rnd2 <= 1'b0;
        end else if (en) begin
          r_t    <= w_t;
          r_a1   <= ina[W+i];
          r_b1   <= inb[W+i];
          r_rnd1 <= rnd[i];
          r_s    <= w_s;
          r_rnd2 <= r_rnd1;
        end
      end

      assign w_out0[i] = r_rnd2;
      assign w_out1[i] = r_s;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld1 <= 1'b0;
      r_vld2 <= 1'b0;
    end else if (en) begin
      r_vld1 <= in_valid;
      r_vld2 <= r_vld1;
    end
  end

  assign w_data    = {w_out1, w_out0};
  assign out_valid = r_vld2;

`ifdef MSK_AND_GHPC_VEC_OUTZERO_EN
  // Gating uses the registered valid only, so out stays a simple function
  // of registers.
  assign out = w_data & {(2*W){r_vld2}};
`else
  assign out = w_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msk_and_ghpc_vec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msk_and_ghpc_vec
//  Purpose  : Self-checking directed bench for msk_and_ghpc_vec (W=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_msk_and_ghpc_vec;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           in_valid;
  logic [2*W-1:0] ina;
  logic [2*W-1:0] inb;
  logic [W-1:0]   rnd;
  logic           out_valid;
  logic [2*W-1:0] out;

  int n_chk;
  int n_err;

  msk_and_ghpc_vec #(.W(W), .d(2)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .ina      (ina),
    .inb      (inb),
    .rnd      (rnd),
    .out_valid(out_valid),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference sharing: share0 = rnd, share1 = (a & b) ^ rnd, per lane.
  function automatic logic [2*W-1:0] f_exp(input logic [2*W-1:0] a,
                                           input logic [2*W-1:0] b,
                                           input logic [W-1:0] r);
    logic [W-1:0] av, bv;
    av = a[W-1:0] ^ a[2*W-1:W];
    bv = b[W-1:0] ^ b[2*W-1:W];
    return {(av & bv) ^ r, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2*W-1:0] a,
                       input logic [2*W-1:0] b, input logic [W-1:0] r);
    in_valid = v;
    ina      = a;
    inb      = b;
    rnd      = r;
  endtask

  logic [2*W-1:0] exp_q [0:31];
  logic [2*W-1:0] va, vb;
  logic [W-1:0]   vr;
  logic [4:0]     cmb;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b1;
    drive(1'b0, '0, '0, '0);
    tick();
    tick();
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_vld", 32'(out_valid), 32'h0);
    rst_n = 1'b1;

    // Reference vector: a=0xC, b=0xA, rnd=0x6 -> out=0xE6
    drive(1'b1, 8'h95, 8'h93, 4'h6);
    tick();
    drive(1'b0, 8'h00, 8'h00, 4'h0);
    tick();
    chk("ref_out", 32'(out), 32'hE6);
    chk("ref_vld", 32'(out_valid), 32'h1);
    chk("ref_unmasked", 32'(out[7:4] ^ out[3:0]), 32'h8);
    tick();
    chk("bubble_vld", 32'(out_valid), 32'h0);

    // Every (a0,a1,b0,b1,rnd) combination, back to back. Lane i uses
    // combination (c + 8*i) mod 32, so the lanes carry different data.
    for (int c = 0; c <= 32; c++) begin
      if (c < 32) begin
        va = '0; vb = '0; vr = '0;
        for (int l = 0; l < W; l++) begin
          cmb = 5'((c + 8 * l) % 32);
          va[l]     = cmb[0];
          va[W + l] = cmb[1];
          vb[l]     = cmb[2];
          vb[W + l] = cmb[3];
          vr[l]     = cmb[4];
        end
        exp_q[c] = f_exp(va, vb, vr);
        drive(1'b1, va, vb, vr);
      end else begin
        drive(1'b0, '0, '0, '0);
      end
      tick();
      if (c >= 1) begin
        chk($sformatf("exh_out%0d", c - 1), 32'(out), 32'(exp_q[c - 1]));
        chk($sformatf("exh_vld%0d", c - 1), 32'(out_valid), 32'h1);
      end
    end
    tick();
    chk("flush_vld", 32'(out_valid), 32'h0);
    chk("flush_out", 32'(out), 32'h0);

    // Stall: one valid set, then en=0 for three edges.
    drive(1'b1, 8'h3A, 8'hC5, 4'h9);
    tick();
    en = 1'b0;
    drive(1'b1, 8'hFF, 8'hFF, 4'hF);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("stall_vld%0d", s), 32'(out_valid), 32'h0);
      chk($sformatf("stall_out%0d", s), 32'(out), 32'h0);
    end
    en = 1'b1;
    drive(1'b0, '0, '0, '0);
    tick();
    chk("stall_res_out", 32'(out), 32'(f_exp(8'h3A, 8'hC5, 4'h9)));
    chk("stall_res_vld", 32'(out_valid), 32'h1);

    // Reset one cycle after a valid input; en low to show reset wins.
    drive(1'b1, 8'hF0, 8'h0F, 4'hA);
    tick();
    drive(1'b0, '0, '0, '0);
    rst_n = 1'b0;
    en    = 1'b0;
    tick();
    chk("rst_mid_out", 32'(out), 32'h0);
    chk("rst_mid_vld", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    chk("rst_nostale_out", 32'(out), 32'h0);
    chk("rst_nostale_vld", 32'(out_valid), 32'h0);

    // Bubble carrying nonzero data.
    drive(1'b0, 8'h6B, 8'hD7, 4'h5);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    chk("bub_vld", 32'(out_valid), 32'h0);
`ifdef MSK_AND_GHPC_VEC_OUTZERO_EN
    chk("bub_out_gated", 32'(out), 32'h0);
`else
    chk("bub_out_raw", 32'(out), 32'(f_exp(8'h6B, 8'hD7, 4'h5)));
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msk_and_ghpc_vec.md
MSK_AND_GHPC_VEC -- requirements
Module: msk_and_ghpc_vec

Interface
REQ-001 SHALL have parameter W, default 8, number of independent bit-lanes.
REQ-002 SHALL have parameter d, default 2, share count; any other value SHALL fail elaboration.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port en  input  1  pipeline advance; 0 freezes every register.
REQ-006 SHALL have port in_valid  input  1  operands on ina/inb are valid this cycle.
REQ-007 SHALL have port ina  input  2*W  sharing of a; bits [W-1:0] share 0, bits [2W-1:W] share 1.
REQ-008 SHALL have port inb  input  2*W  sharing of b; same packing as ina.
REQ-009 SHALL have port rnd  input  W  one fresh random bit per lane, sampled with the operands.
REQ-010 SHALL have port out_valid  output  1  out holds a valid result.
REQ-011 SHALL have port out  output  2*W  sharing of a&b; same packing as ina.

Function
REQ-012 Lane i SHALL be an independent 2-share GHPC AND; lanes SHALL share no logic or randomness.
REQ-013 Stage 1 (en=1): lane i SHALL register T[k] = ((a0^k[1]) & (b0^k[0])) ^ rnd[i] for k in 0..3, plus a1, b1 and rnd[i].
REQ-014 Stage 1 SHALL consume only share 0 combinationally; share 1 SHALL pass through a register before any use.
REQ-015 Stage 2 (en=1): lane i SHALL register T[{a1,b1}] by one-hot AND-mask of all four T entries followed by XOR-reduction, plus the delayed rnd[i].
REQ-016 out share 1 lane i SHALL be the stage-2 filtered bit; out share 0 lane i SHALL be rnd[i] delayed two advancing cycles.
REQ-017 Latency SHALL be exactly 2 cycles with en=1: inputs sampled at edge n appear on out after edge n+1.
REQ-018 out share 0 XOR out share 1 SHALL equal (a0^a1)&(b0^b1) per lane.
REQ-019 Throughput SHALL be one operand set per cycle with en=1; no back-pressure signal exists.
REQ-020 out_valid SHALL be in_valid delayed through the same 2 registers, advancing only when en=1.
REQ-021 Data registers SHALL advance on en=1 regardless of in_valid; bubbles SHALL propagate as out_valid=0.
REQ-022 With en=0, all registers SHALL hold; out and out_valid SHALL stay constant.
REQ-023 out SHALL be driven directly from registers with no output logic (glitch-free boundary), except as REQ-029 permits.

Reset
REQ-024 rst_n=0 at a rising edge SHALL clear every register (data, random, valid) to 0, dominating en.
REQ-025 After reset, out SHALL be 0 and out_valid 0 until a valid input has traversed 2 advancing cycles.
REQ-026 Reset mid-operation SHALL discard all in-flight results; out_valid SHALL be 0 the cycle after the reset edge.

Configuration
REQ-027 Macro MSK_AND_GHPC_VEC_OUTZERO_EN SHALL select output gating.
REQ-028 Without the macro, out SHALL expose the stage-2 registers unconditionally.
REQ-029 With the macro, out SHALL be forced to 0 whenever out_valid=0, via an AND with the registered out_valid.

Verification
REQ-030 W=4, en=1, ina=0x95, inb=0x93, rnd=0x6, in_valid=1 -> 2 cycles later out=0xE6, out_valid=1 (unmasked 0x8).
REQ-031 Exhaustive W=1: all 16 (a0,a1,b0,b1) x rnd in {0,1} -> out[0]=rnd, out[0]^out[1]=a&b every time.
REQ-032 Back-to-back valid inputs for 8 cycles with en=1 -> 8 consecutive correct results, out_valid high 8 cycles.
REQ-033 Valid input, then en=0 for 3 cycles after edge 1 -> out_valid rises only after the 2nd advancing edge; out stable while en=0.
REQ-034 rst_n=0 one cycle after a valid input -> out=0, out_valid=0 next cycle; no stale result ever appears.
REQ-035 With MSK_AND_GHPC_VEC_OUTZERO_EN, in_valid=0 bubble with nonzero ina/inb/rnd -> out=0 while out_valid=0.
